// File: rtl/mpu_det_seq_pkg.sv
// Shared types, constants and helpers for the sequential determinant unit.
// MPU_DET_SEQ_DET5_EN enables 5x5 determinants; without it size 5 is rejected.
package mpu_pkg;

   localparam int MAT_DIM = 5;
   localparam int ELEM_W  = 8;
   localparam int MAT_W   = MAT_DIM * MAT_DIM * ELEM_W;

   localparam logic [4:0] STEPS_SMALL = 5'd1;
   localparam logic [4:0] STEPS_4     = 5'd4;
`ifdef MPU_DET_SEQ_DET5_EN
   localparam logic [4:0] STEPS_5     = 5'd20;
`endif

   typedef logic signed [ELEM_W-1:0] int8_t;
   typedef logic [MAT_W-1:0]         mat_t;
   typedef logic [2:0]               idx_t;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   // Bit offset of element (r,c) in the row-major packed matrix.
   function automatic int elem_off(input int r, input int c);
      return r * MAT_DIM * ELEM_W + c * ELEM_W;
   endfunction

   function automatic logic size_valid(input int8_t size);
`ifdef MPU_DET_SEQ_DET5_EN
      return (size >= 8'sd1) && (size <= 8'sd5);
`else
      return (size >= 8'sd1) && (size <= 8'sd4);
`endif
   endfunction

   function automatic logic [4:0] steps_for(input int8_t size);
      case (size)
         8'sd4:   return STEPS_4;
`ifdef MPU_DET_SEQ_DET5_EN
         8'sd5:   return STEPS_5;
`endif
         default: return STEPS_SMALL;
      endcase
   endfunction

   // k-th (0..2) column of 0..4 in ascending order that is neither e0 nor e1.
   function automatic idx_t pick_col(input idx_t e0, input idx_t e1, input int k);
      int   n;
      idx_t col;
      n   = 0;
      col = '0;
      for (int c = 0; c < MAT_DIM; c++) begin
         if (idx_t'(c) != e0 && idx_t'(c) != e1) begin
            if (n == k) col = idx_t'(c);
            n++;
         end
      end
      return col;
   endfunction

endpackage

// File: rtl/mpu_det_seq_if.sv
// Request/response bundle of the sequential determinant unit.
// Shared by all builds; MPU_DET_SEQ_DET5_EN does not change the signal set.
interface mpu_det_seq_if;
   import mpu_pkg::*;

   logic  start;
   int8_t size;
   mat_t  matrix;
   logic  busy;
   logic  done;
   logic  error;
   int8_t result;

   modport master (
      output start, size, matrix,
      input  busy, done, error, result
   );

   modport slave (
      input  start, size, matrix,
      output busy, done, error, result
   );

endinterface

// File: rtl/mpu_det_seq_det3_unit.sv
// Combinational 3x3 determinant by the rule of Sarrus, wrapping to 8 bits.
// Identical in every build; MPU_DET_SEQ_DET5_EN only changes how it is fed.
module mpu_det3_unit
   import mpu_pkg::*;
(
   input  int8_t m [9],
   output int8_t det
);

   int8_t ae, bf, cd, ce, bd, af;
   int8_t p0, p1, p2, n0, n1, n2;

   // Each product is truncated to 8 bits before the next multiply.
   always_comb begin
      ae  = m[0] * m[4];
      p0  = ae * m[8];
      bf  = m[1] * m[5];
      p1  = bf * m[6];
      cd  = m[2] * m[3];
      p2  = cd * m[7];
      ce  = m[2] * m[4];
      n0  = ce * m[6];
      bd  = m[1] * m[3];
      n1  = bd * m[8];
      af  = m[0] * m[5];
      n2  = af * m[7];
      det = p0 + p1 + p2 - n0 - n1 - n2;
   end

endmodule

// File: rtl/mpu_det_seq.sv
// Sequential int8 determinant of the top-left 1x1..5x5 submatrix, one 3x3 minor per clock.
// Define MPU_DET_SEQ_DET5_EN to build the 5x5 outer expansion; otherwise size 5 is an error.
module mpu_det_seq
   import mpu_pkg::*;
(
   input logic         clock,
   input logic         reset,
   mpu_det_seq_if.slave bus
);

   state_t     state_q, state_d;
   mat_t       mat_q;
   int8_t      size_q;
   logic [4:0] cnt_q;
   int8_t      acc_q, sacc_q, result_q;
   logic       error_q;

   logic       busy_c, done_c, last, job_valid;
   logic [1:0] j;
   int8_t      d3_in [9];
   int8_t      d3;
   int8_t      term, acc_d, sacc_d, final_d;

`ifdef MPU_DET_SEQ_DET5_EN
   idx_t       i, cp;
   int8_t      inner, s_new, outer;
   assign i  = cnt_q[4:2];
   // Column of the original matrix that inner index j refers to inside the minor without column i.
   assign cp = (idx_t'(j) < i) ? idx_t'(j) : idx_t'(j) + 3'd1;
`endif

   function automatic int8_t el(input mat_t m, input int r, input int c);
      return m[elem_off(r, c) +: ELEM_W];
   endfunction

   assign j         = cnt_q[1:0];
   assign job_valid = size_valid(size_q);
   assign last      = (cnt_q == steps_for(size_q) - 5'd1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy_c  = 1'b0;
      done_c  = 1'b0;
      case (state_q)
         IDLE: if (bus.start) state_d = CALC;
         CALC: begin
            busy_c = 1'b1;
            if (last) state_d = DONE;
         end
         DONE: begin
            busy_c  = 1'b1;
            done_c  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Select the 3x3 minor for this step; small sizes are padded out with an identity.
   always_comb begin
      for (int k = 0; k < 9; k++) d3_in[k] = '0;
      if (size_q == 8'sd4) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               d3_in[r*3+c] = el(mat_q, r + 1, int'(pick_col(idx_t'(j), 3'd4, c)));
      end
`ifdef MPU_DET_SEQ_DET5_EN
      else if (size_q == 8'sd5) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               d3_in[r*3+c] = el(mat_q, r + 2, int'(pick_col(i, cp, c)));
      end
`endif
      else begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               d3_in[r*3+c] = (r < int'(size_q) && c < int'(size_q)) ? el(mat_q, r, c)
                            : ((r == c) ? 8'sd1 : 8'sd0);
      end
   end

   mpu_det3_unit u_det3 (
      .m   (d3_in),
      .det (d3)
   );

   always_comb begin
      acc_d   = acc_q;
      sacc_d  = sacc_q;
      final_d = '0;
      term    = '0;
`ifdef MPU_DET_SEQ_DET5_EN
      inner   = '0;
      s_new   = '0;
      outer   = '0;
`endif
      if (size_q == 8'sd4) begin
         term = el(mat_q, 0, int'(j)) * d3;
         if (j[0]) term = -term;
         acc_d   = acc_q + term;
         final_d = acc_d;
      end
`ifdef MPU_DET_SEQ_DET5_EN
      else if (size_q == 8'sd5) begin
         inner = el(mat_q, 1, int'(cp)) * d3;
         if (j[0]) inner = -inner;
         s_new = sacc_q + inner;
         outer = el(mat_q, 0, int'(i)) * s_new;
         if (i[0]) outer = -outer;
         if (j == 2'd3) begin
            acc_d  = acc_q + outer;
            sacc_d = '0;
         end else begin
            sacc_d = s_new;
         end
         final_d = acc_d;
      end
`endif
      else if (job_valid) begin
         final_d = d3;
      end
   end

   // Operands are captured at accept; result/error only move on the final step.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mat_q    <= '0;
         size_q   <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         sacc_q   <= '0;
         result_q <= '0;
         error_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus.start) begin
               mat_q  <= bus.matrix;
               size_q <= bus.size;
               cnt_q  <= '0;
               acc_q  <= '0;
               sacc_q <= '0;
            end
            CALC: begin
               acc_q  <= acc_d;
               sacc_q <= sacc_d;
               if (last) begin
                  result_q <= job_valid ? final_d : 8'sd0;
                  error_q  <= ~job_valid;
               end else begin
                  cnt_q <= cnt_q + 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy   = busy_c;
   assign bus.done   = done_c;
   assign bus.error  = error_q;
   assign bus.result = result_q;

endmodule

// File: doc/mpu_det_seq.md
MPU_DET_SEQ -- requirements
Module: mpu_det_seq

Interface
REQ-001 Parameters: none; element width (8) and matrix dimension (5) are fixed package constants.
REQ-002 clock  in  1  single clock; all state updates on posedge clock.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  request; sampled only in IDLE.
REQ-005 size  in  8  signed order of determinant (1..5), sampled with start.
REQ-006 matrix  in  200 [0:199]  signed 5x5 int8, row-major; element (r,c) at bits [r*40+c*8 +: 8]; sampled with start.
REQ-007 busy  out  1  high from accept edge until return to IDLE.
REQ-008 done  out  1  one-cycle completion pulse.
REQ-009 error  out  1  size invalid for last accepted request; valid with done, held until next accept.
REQ-010 result  out  8  signed determinant of the top-left size x size submatrix; valid from done, held until next accept.

Function
REQ-011 FSM states: IDLE, CALC, DONE; IDLE->CALC on posedge with start=1; CALC->DONE after N steps; DONE->IDLE unconditionally next edge.
REQ-012 Accept edge latches matrix and size into internal registers and clears accumulators; later input changes have no effect on the running job.
REQ-013 Step count N: size 1,2,3 -> 1; size 4 -> 4; size 5 -> 20; invalid size -> 1.
REQ-014 One CALC step per clock; each step uses exactly one mpu_det3_unit evaluation plus one or two int8 multiplies.
REQ-015 Size 1: result = m(0,0); size 2: m00*m11 - m01*m10; size 3: Det3 of rows/cols 0..2.
REQ-016 Size 4: step j (0..3) adds (-1)^j * m(0,j) * Det3(rows 1..3, cols 0..3 excluding j).
REQ-017 Size 5: outer i (0..4), inner j (0..3); inner sum S_i = sum (-1)^j * a(0,j) * Det3(remaining 3x3) over the 4x4 minor rows 1..4, cols excluding i; outer adds (-1)^i * m(0,i) * S_i after j=3; S cleared at each new i.
REQ-018 All arithmetic is two's-complement, truncated to 8 bits after every multiply/add (wrap, no saturation, no overflow flag).
REQ-019 done asserts for exactly one cycle, N clock edges after the accept edge; busy is high in CALC and DONE, low in IDLE.
REQ-020 Invalid size (<=0 or >5): one CALC step, then done=1, error=1, result=0.
REQ-021 start asserted while busy is ignored (not queued); start held high in IDLE during DONE->IDLE edge is accepted on the following edge only.
REQ-022 result and error update only on the CALC->DONE edge.

Reset
REQ-023 reset=1 forces IDLE immediately, regardless of clock; busy=0, done=0, error=0, result=0, step counters and accumulators=0.
REQ-024 Reset mid-job abandons the job; no done pulse is produced for it.

Configuration
REQ-025 Macro MPU_DET_SEQ_DET5_EN: defined -> size 5 supported per REQ-017; undefined -> size 5 treated as invalid per REQ-020 and the 5x5 outer-loop logic is not compiled.

Structure
REQ-026 Package mpu_pkg holds: int8 typedef, 200-bit matrix typedef, MAT_DIM=5, ELEM_W=8, element-offset function, FSM state enum, step counts per size.
REQ-027 Sub-module mpu_det3_unit: combinational 3x3 int8 determinant (Sarrus, 8-bit wrap), single instance in mpu_det_seq.

Verification
REQ-028 5x5 identity, size=5 (DET5_EN defined) -> done 20 edges after accept, result=1, error=0.
REQ-029 size=2, [[3,4],[2,5]] -> done 1 edge after accept, result=7.
REQ-030 size=4, diag(2,3,1,-1) -> done after 4 edges, result=-6; swap rows 0/1 -> result=6.
REQ-031 size=3, diag(10,10,10) -> result=-24 (1000 mod 256 wrap).
REQ-032 size=0 -> done after 1 edge, error=1, result=0; start pulses during a size-5 job -> ignored, exactly one done.
REQ-033 reset asserted at step 10 of a size-5 job -> busy=0, done=0, result=0 immediately; no later done; DET5_EN undefined with size=5 -> error=1.
